// File: rtl/fetch_pkg.sv
// Shared widths and types for the instruction fetch unit.
package fetch_pkg;
    localparam int ADDR_W  = 72;
    localparam int INSTR_W = 60;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with clear; push and pop may coincide at any fill level.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  fetch_entry_t     push_data_i,
    input  logic             pop_i,
    input  logic             clear_i,
    output fetch_entry_t     head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);
    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    // Storage needs no reset; the head is only meaningful while count is non-zero.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues in-order instruction reads, buffers {pc, instr} for decode and drops stale
// responses after a redirect. Define FETCH_BYPASS_EN to forward a response straight to decode.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic               pc_advance,
    input  logic               redirect,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [ADDR_W-1:0]  dec_pc,
    output logic               busy_drain
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0] CAP = FIFO_DEPTH[CNT_W:0];

    fetch_state_t     state_q;
    logic [CNT_W-1:0] drop_cnt_q;
    logic [CNT_W-1:0] drop_cnt_d;
    logic [CNT_W-1:0] stale_cnt;
    logic [CNT_W-1:0] buf_count;
    logic [CNT_W-1:0] outstanding;
    logic             buf_empty, buf_full, tag_full, tag_empty;
    fetch_entry_t     buf_head, tag_head, buf_push_data, tag_push_data;
    logic             fetching, rsp_live, req_valid, bypass;
    logic             buf_push, buf_pop, unused_ok;

    // Valid/ready: a request transfers when imem_req_valid & imem_req_ready, a decode entry when
    // dec_valid & dec_ready; valid never depends on the matching ready.
    assign fetching   = (state_q == FETCH) && !redirect;
    assign rsp_live   = fetching && imem_rsp_valid;
    assign req_valid  = fetching && (({1'b0, buf_count} + {1'b0, outstanding}) < CAP);

    assign imem_req_valid = req_valid;
    assign imem_req_addr  = req_valid ? pc_in : '0;
    assign pc_advance     = req_valid && imem_req_ready;
    assign busy_drain     = (state_q == DRAIN);

`ifdef FETCH_BYPASS_EN
    assign bypass = rsp_live && buf_empty;
`else
    assign bypass = 1'b0;
`endif

    assign dec_valid = !buf_empty || bypass;
    assign buf_push  = rsp_live && !(bypass && dec_ready);
    assign buf_pop   = !buf_empty && dec_ready;

    always_comb begin
        dec_instr = '0;
        dec_pc    = '0;
        if (!buf_empty) begin
            dec_instr = buf_head.instr;
            dec_pc    = buf_head.pc;
        end else if (bypass) begin
            dec_instr = imem_rsp_data;
            dec_pc    = tag_head.pc;
        end
    end

    assign buf_push_data = '{pc: tag_head.pc, instr: imem_rsp_data};
    assign tag_push_data = '{pc: pc_in, instr: '0};

    // Responses still owed once a redirect lands; a response in the redirect cycle is dropped too.
    assign stale_cnt  = outstanding - CNT_W'(imem_rsp_valid);
    assign drop_cnt_d = drop_cnt_q - CNT_W'(imem_rsp_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            drop_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: state_q <= FETCH;
                FETCH: begin
                    if (redirect) begin
                        drop_cnt_q <= stale_cnt;
                        if (stale_cnt != '0) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    drop_cnt_q <= drop_cnt_d;
                    if (drop_cnt_d == '0) state_q <= FETCH;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_buf (
        .clk         (clk),
        .rst         (rst),
        .push_i      (buf_push),
        .push_data_i (buf_push_data),
        .pop_i       (buf_pop),
        .clear_i     (redirect),
        .head_o      (buf_head),
        .count_o     (buf_count),
        .full_o      (buf_full),
        .empty_o     (buf_empty)
    );

    // Tag FIFO holds the PC of every in-flight request; its occupancy is the outstanding count.
    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_tag (
        .clk         (clk),
        .rst         (rst),
        .push_i      (pc_advance),
        .push_data_i (tag_push_data),
        .pop_i       (rsp_live),
        .clear_i     (redirect),
        .head_o      (tag_head),
        .count_o     (outstanding),
        .full_o      (tag_full),
        .empty_o     (tag_empty)
    );

    assign unused_ok = ^{tag_head.instr, tag_full, tag_empty, buf_full};
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Random-stimulus bench for instr_fetch_unit: in-order memory model, PC model and decode scoreboard.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [ADDR_W-1:0]  pc_in = '0;
    logic               pc_advance;
    logic               redirect = 1'b0;
    logic               imem_req_valid;
    logic               imem_req_ready = 1'b0;
    logic [ADDR_W-1:0]  imem_req_addr;
    logic               imem_rsp_valid = 1'b0;
    logic [INSTR_W-1:0] imem_rsp_data = '0;
    logic               dec_valid;
    logic               dec_ready = 1'b0;
    logic [INSTR_W-1:0] dec_instr;
    logic [ADDR_W-1:0]  dec_pc;
    logic               busy_drain;

    instr_fetch_unit #(.FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc_in),
        .pc_advance     (pc_advance),
        .redirect       (redirect),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .busy_drain     (busy_drain)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        int                due;
        bit                stale;
    } mem_req_t;

    mem_req_t          mem_q[$];
    logic [ADDR_W-1:0] exp_q[$];
    int                arrived_cnt, stale_cnt, cyc, last_due, adv_seen;
    int                ready_pct, dready_pct, redir_pm, lat_min, lat_max, redir_at_inflight;
    bit                fixed_target_en;
    logic [ADDR_W-1:0] fixed_target, pc_model, redir_target;
    int                checks, errors;

    function automatic logic [INSTR_W-1:0] instr_of(input logic [ADDR_W-1:0] addr);
        return addr[59:0] ^ {addr[71:60], 48'h0} ^ 60'h0F1E2D3C4B5A697;
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic reset_dut();
        @(posedge clk); #1;
        rst            = 1'b1;
        redirect       = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        dec_ready      = 1'b0;
        pc_in          = pc_model;
        mem_q.delete();
        exp_q.delete();
        arrived_cnt = 0;
        stale_cnt   = 0;
        last_due    = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_req_valid", imem_req_valid, 0);
        check_eq("rst_pc_advance", pc_advance, 0);
        check_eq("rst_req_addr", imem_req_addr, 0);
        check_eq("rst_dec_valid", dec_valid, 0);
        check_eq("rst_dec_instr", dec_instr, 0);
        check_eq("rst_dec_pc", dec_pc, 0);
        check_eq("rst_busy_drain", busy_drain, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_req_valid", imem_req_valid, 0);
    endtask

    // One clock: drive memory/decode/redirect, check outputs mid-cycle, then advance the model.
    task automatic step();
        bit          rsp_now, live, exp_dv, exp_req, accept, popped, byp_take;
        int          lat;
        logic [95:0] r96;
        @(posedge clk); #1;
        cyc++;
        rsp_now = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        imem_rsp_valid = rsp_now;
        imem_rsp_data  = '0;
        if (rsp_now) imem_rsp_data = instr_of(mem_q[0].addr);
        imem_req_ready = ($urandom_range(99) < ready_pct);
        dec_ready      = ($urandom_range(99) < dready_pct);
        redirect       = ($urandom_range(999) < redir_pm);
        if (redir_at_inflight >= 0 && stale_cnt == 0 && mem_q.size() == redir_at_inflight && !rsp_now) begin
            redirect          = 1'b1;
            redir_at_inflight = -1;
        end
        r96 = {$urandom, $urandom, $urandom};
        redir_target = fixed_target_en ? fixed_target : r96[ADDR_W-1:0];
        pc_in = pc_model;

        @(negedge clk);
        live   = rsp_now && !mem_q[0].stale && !redirect;
        exp_dv = (arrived_cnt > 0) || (BYP && live);
        check_eq("dec_valid", dec_valid, exp_dv);
        if (exp_dv && dec_valid) begin
            check_eq("dec_pc", dec_pc, exp_q[0]);
            check_eq("dec_instr", dec_instr, instr_of(exp_q[0]));
        end
        exp_req = !redirect && stale_cnt == 0 && exp_q.size() < DEPTH;
        check_eq("req_valid", imem_req_valid, exp_req);
        check_eq("pc_advance", pc_advance, exp_req && imem_req_ready);
        if (exp_req) check_eq("req_addr", imem_req_addr, pc_model);
        check_eq("busy_drain", busy_drain, stale_cnt > 0);
        if (pc_advance) adv_seen++;

        accept   = exp_req && imem_req_ready;
        popped   = exp_dv && dec_ready && !redirect;
        byp_take = popped && arrived_cnt == 0;
        if (rsp_now) begin
            if (mem_q[0].stale) stale_cnt--;
            else if (!redirect && !byp_take) arrived_cnt++;
            mem_q.delete(0);
        end
        if (popped) begin
            exp_q.delete(0);
            if (!byp_take) arrived_cnt--;
        end
        if (accept) begin
            lat = int'($urandom_range(lat_max, lat_min));
            last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            mem_q.push_back('{addr: pc_model, due: last_due, stale: 1'b0});
            exp_q.push_back(pc_model);
            pc_model = pc_model + 1'b1;
        end
        if (redirect) begin
            exp_q.delete();
            arrived_cnt = 0;
            foreach (mem_q[i]) mem_q[i].stale = 1'b1;
            stale_cnt = mem_q.size();
            pc_model  = redir_target;
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; adv_seen = 0;
        pc_model = 'h10; fixed_target = '0; fixed_target_en = 1'b0; redir_at_inflight = -1;
        ready_pct = 100; dready_pct = 100; redir_pm = 0; lat_min = 1; lat_max = 1;
        reset_dut();

        // Streaming, latency 1, everything ready.
        adv_seen = 0;
        run(4);
        check_eq("stream_adv", adv_seen, 4);
        run(6);

        // Decode backpressure fills the buffer, then releases.
        dready_pct = 0;
        run(10);
        check_eq("bp_req_valid", imem_req_valid, 0);
        dready_pct = 100;
        run(10);

        // Memory stall at 0x20.
        ready_pct = 0;
        run(5);
        fixed_target_en = 1'b1; fixed_target = 'h20; redir_at_inflight = 0;
        run(1);
        run(3);
        adv_seen = 0; ready_pct = 100;
        run(1);
        check_eq("stall_accept_once", adv_seen, 1);

        // Redirect to 0x80 with two requests in flight at latency 3.
        lat_min = 3; lat_max = 3; fixed_target = 'h80; redir_at_inflight = 2;
        run(25);
        fixed_target_en = 1'b0;

        for (int s = 0; s < 30; s++) begin
            ready_pct  = int'($urandom_range(100, 30));
            dready_pct = int'($urandom_range(100, 20));
            redir_pm   = int'($urandom_range(40, 0));
            lat_min    = int'($urandom_range(3, 1));
            lat_max    = lat_min + int'($urandom_range(3, 0));
            if (s == 15) reset_dut();
            run(100);
        end

        ready_pct = 0; dready_pct = 100; redir_pm = 0;
        for (int k = 0; k < 200 && (mem_q.size() > 0 || exp_q.size() > 0); k++) step();
        check_eq("final_drain", (mem_q.size() == 0) && (exp_q.size() == 0), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
